// File: rtl/kgp_operand_stage.sv
// Operand front end for the 16-bit prefix adder: encodes add/sub operands into
// generate/propagate vectors behind a 2-entry skid buffer with registered in_ready.
module kgp_operand_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   kgp_one,
  output logic [WIDTH:0]   kgp_two,
  output logic             out_sub,
  output logic [15:0]      xfer_count
);

  logic             m_valid_q, m_valid_d;
  logic [WIDTH:0]   m_g_q, m_g_d;
  logic [WIDTH:0]   m_p_q, m_p_d;
  logic             m_sub_q, m_sub_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH:0]   s_g_q, s_g_d;
  logic [WIDTH:0]   s_p_q, s_p_d;
  logic             s_sub_q, s_sub_d;
  logic [15:0]      xfer_count_q, xfer_count_d;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   new_g;
  logic [WIDTH:0]   new_p;
  logic             accept;
  logic             xfer;
  logic             m_free;

  // Subtraction is a + ~b + 1, so only the encoded g/p vectors need storing.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
  assign new_g   = {a & b_eff, cin_eff};
  assign new_p   = {a ^ b_eff, 1'b0};

  assign accept = in_valid & ~s_valid_q;
  assign xfer   = m_valid_q & out_ready;
  assign m_free = ~m_valid_q | xfer;

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path leaves it unassigned (no latches).
    m_valid_d    = m_valid_q;
    m_g_d        = m_g_q;
    m_p_d        = m_p_q;
    m_sub_d      = m_sub_q;
    s_valid_d    = s_valid_q;
    s_g_d        = s_g_q;
    s_p_d        = s_p_q;
    s_sub_d      = s_sub_q;
    xfer_count_d = xfer_count_q + {15'd0, xfer};

    if (m_free) begin
      if (s_valid_q) begin
        // in_ready is low while S is full, so no new pair competes for M here.
        m_valid_d = 1'b1;
        m_g_d     = s_g_q;
        m_p_d     = s_p_q;
        m_sub_d   = s_sub_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_g_d     = new_g;
        m_p_d     = new_p;
        m_sub_d   = sub;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_g_d     = new_g;
      s_p_d     = new_p;
      s_sub_d   = sub;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q    <= 1'b0;
      m_g_q        <= '0;
      m_p_q        <= '0;
      m_sub_q      <= 1'b0;
      s_valid_q    <= 1'b0;
      s_g_q        <= '0;
      s_p_q        <= '0;
      s_sub_q      <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_g_q        <= m_g_d;
      m_p_q        <= m_p_d;
      m_sub_q      <= m_sub_d;
      s_valid_q    <= s_valid_d;
      s_g_q        <= s_g_d;
      s_p_q        <= s_p_d;
      s_sub_q      <= s_sub_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign in_ready   = ~s_valid_q;
  assign out_valid  = m_valid_q;
  assign kgp_one    = m_g_q;
  assign kgp_two    = m_p_q;
  assign out_sub    = m_sub_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_kgp_operand_stage.sv
// Self-checking bench for kgp_operand_stage: directed cases plus randomized
// handshake traffic against a queue-based occupancy/arithmetic reference model.
module tb_kgp_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] kgp_one;
  logic [16:0] kgp_two;
  logic        out_sub;
  logic [15:0] xfer_count;

  kgp_operand_stage #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .kgp_one    (kgp_one),
    .kgp_two    (kgp_two),
    .out_sub    (out_sub),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
  } pair_t;

  pair_t       model_q[$];
  int          model_xfers;
  int          tests_run;
  int          tests_failed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Carry-ripple through the g/p vectors, as the downstream prefix+sum stage would.
  function automatic logic [15:0] sum_from_kgp(input logic [16:0] g, input logic [16:0] p);
    logic [15:0] s;
    logic        c;
    c = g[0];
    for (int i = 0; i < 16; i++) begin
      s[i] = p[i+1] ^ c;
      c    = g[i+1] | (p[i+1] & c);
    end
    return s;
  endfunction

  function automatic logic [15:0] arith_result(input pair_t t);
    if (t.sub) return 16'(t.a - t.b);
    return 16'(t.a + t.b + {15'd0, t.cin});
  endfunction

  task automatic compare_outputs();
    pair_t       t;
    logic [15:0] bx;
    check("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
    check("xfer_count", 32'(xfer_count), 32'(model_xfers % 65536));
    if (model_q.size() > 0) begin
      t  = model_q[0];
      bx = t.sub ? ~t.b : t.b;
      check("kgp_one", 32'(kgp_one), 32'({t.a & bx, t.sub | t.cin}));
      check("kgp_two", 32'(kgp_two), 32'({t.a ^ bx, 1'b0}));
      check("out_sub", 32'(out_sub), 32'(t.sub));
      check("sum", 32'(sum_from_kgp(kgp_one, kgp_two)), 32'(arith_result(t)));
    end
  endtask

  // Called at a negedge: drive inputs, advance the model at posedge, check at next negedge.
  task automatic cycle(input logic iv, input logic [15:0] a_i, input logic [15:0] b_i,
                       input logic cin_i, input logic sub_i, input logic ordy);
    pair_t t;
    logic  exp_acc;
    logic  exp_xfer;
    in_valid  = iv;
    a         = a_i;
    b         = b_i;
    cin       = cin_i;
    sub       = sub_i;
    out_ready = ordy;
    @(posedge clk);
    exp_acc  = iv && (model_q.size() < 2);
    exp_xfer = ordy && (model_q.size() > 0);
    if (exp_xfer) begin
      void'(model_q.pop_front());
      model_xfers++;
    end
    if (exp_acc) begin
      t.a = a_i; t.b = b_i; t.cin = cin_i; t.sub = sub_i;
      model_q.push_back(t);
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    int          start;
    int          budget;
    logic        iv;
    logic        ordy;
    tests_run    = 0;
    tests_failed = 0;
    model_xfers  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_kgp_one", 32'(kgp_one), 32'd0);
    check("rst_kgp_two", 32'(kgp_two), 32'd0);
    check("rst_xfer", 32'(xfer_count), 32'd0);
    reset = 1'b0;

    // Plain add vector, accepted in the first cycle after reset.
    cycle(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_kgp_one", 32'(kgp_one), 32'h00002);
    check("add_kgp_two", 32'(kgp_two), 32'h001FC);
    idle(1'b1);

    // Subtract vector: 5 - 3.
    cycle(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, 1'b1);
    check("sub_cin", 32'(kgp_one[0]), 32'd1);
    check("sub_kgp_two", 32'(kgp_two), 32'h1FFF2);
    check("sub_out_sub", 32'(out_sub), 32'd1);
    check("sub_sum", 32'(sum_from_kgp(kgp_one, kgp_two)), 32'h0002);
    idle(1'b1);

    // Eight back-to-back pairs at full throughput.
    start = model_xfers;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    idle(1'b1);
    check("stream_xfers", 32'(model_xfers - start), 32'd8);
    check("stream_count", 32'(xfer_count), 32'(start + 8));

    // Backpressure: three offered, two accepted, then drain in order.
    cycle(1'b1, 16'h1111, 16'h0101, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h2222, 16'h0202, 1'b1, 1'b0, 1'b0);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'h3333, 16'h0303, 1'b0, 1'b1, 1'b0);
    check("bp_held_kgp_one", 32'(kgp_one), 32'({16'h1111 & 16'h0101, 1'b0}));
    check("bp_depth", 32'(model_q.size()), 32'd2);
    idle(1'b0);
    idle(1'b1);
    check("bp_second", 32'(kgp_two), 32'({16'h2222 ^ 16'h0202, 1'b0}));
    idle(1'b1);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset while both M and S hold data.
    cycle(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hBBBB, 16'h4444, 1'b0, 1'b1, 1'b0);
    check("prerst_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_kgp_one", 32'(kgp_one), 32'd0);
    check("midrst_kgp_two", 32'(kgp_two), 32'd0);
    check("midrst_out_sub", 32'(out_sub), 32'd0);
    check("midrst_xfer", 32'(xfer_count), 32'd0);
    model_q.delete();
    model_xfers = 0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 16'h0F0F, 16'h00F0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check("postrst_xfer", 32'(xfer_count), 32'd1);

    // Randomized valid/ready toggling against the queue model.
    start  = model_xfers;
    budget = 0;
    while ((model_xfers - start) < 3000 && budget < 20000) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      cycle(iv, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy);
      budget++;
    end
    check("rand_done", 32'(model_xfers - start >= 3000), 32'd1);
    while (model_q.size() > 0 && budget < 20100) begin
      idle(1'b1);
      budget++;
    end
    check("rand_drained", 32'(out_valid), 32'd0);
    check("rand_count", 32'(xfer_count), 32'(model_xfers % 65536));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
